// File: rtl/fp_mac_accum_seq.sv
// Sequential dot-product controller around an external combinational FMA
// (z = a*b + c): streams operand pairs in and emits one sum-of-products per job.
module fp_mac_accum_seq #(
  parameter  int SIG_WIDTH = 23,
  parameter  int EXP_WIDTH = 8,
  parameter  int LEN_WIDTH = 8,
  localparam int W         = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [W-1:0]         c_init,
  input  logic [2:0]           rnd,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  output logic [W-1:0]         mac_a,
  output logic [W-1:0]         mac_b,
  output logic [W-1:0]         mac_c,
  output logic [2:0]           mac_rnd,
  input  logic [W-1:0]         mac_z,
  input  logic [7:0]           mac_status,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_z,
  output logic [7:0]           out_status,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [W-1:0]         acc_r;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [2:0]           rnd_r;
  logic [5:0]           sticky_r;
  logic [1:0]           last_r;

  logic in_ready_r;
  logic out_valid_r;
  logic busy_r;
  logic in_ready_s;
  logic out_valid_s;
  logic busy_s;

  logic start_s;
  logic xfer_s;
  logic last_xfer_s;

  assign start_s     = start && (state_r == ST_IDLE);
  assign xfer_s      = in_valid && in_ready_r;
  assign last_xfer_s = xfer_s && (cnt_r == LEN_WIDTH'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an empty job goes straight to DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len == {LEN_WIDTH{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ACC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (last_xfer_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the handshake outputs come straight from flops.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b1;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_ACC: begin
        in_ready_s = 1'b1;
      end
      ST_DONE: begin
        out_valid_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  // Accumulator, remaining count, held rounding mode and job status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {W{1'b0}};
      cnt_r    <= {LEN_WIDTH{1'b0}};
      rnd_r    <= 3'd0;
      sticky_r <= 6'd0;
      last_r   <= 2'd0;
    end else if (start_s) begin
      acc_r    <= c_init;
      cnt_r    <= len;
      rnd_r    <= rnd;
      sticky_r <= 6'd0;
      last_r   <= 2'd0;
    end else if (xfer_s) begin
      acc_r    <= mac_z;
      cnt_r    <= cnt_r - LEN_WIDTH'(1);
      sticky_r <= sticky_r | mac_status[7:2];
      last_r   <= mac_status[1:0];
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign out_z      = acc_r;
  assign out_status = {sticky_r, last_r};

  assign mac_a   = in_a;
  assign mac_b   = in_b;
  assign mac_c   = acc_r;
  assign mac_rnd = rnd_r;

endmodule

// File: tb/tb_fp_mac_accum_seq.sv
// Self-checking bench for fp_mac_accum_seq: a stand-in MAC plus a job-level
// reference model, directed test-plan jobs and randomized jobs.
module tb_fp_mac_accum_seq;
  localparam int W  = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [W-1:0]  c_init = '0;
  logic [2:0]    rnd = 3'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [W-1:0]  mac_a, mac_b, mac_c, mac_z;
  logic [2:0]    mac_rnd;
  logic [7:0]    mac_status;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_z;
  logic [7:0]    out_status;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pa [256];
  logic [W-1:0] pb [256];

  logic [W-1:0] obs_z;
  logic [7:0]   obs_st;
  int           obs_lat, obs_bub;
  bit           obs_stable, obs_rnd_ok, obs_ready_seen, obs_timeout, obs_idle_after;

  fp_mac_accum_seq #(.SIG_WIDTH(23), .EXP_WIDTH(8), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .c_init(c_init), .rnd(rnd),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_rnd(mac_rnd),
    .mac_z(mac_z), .mac_status(mac_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_status(out_status), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in MAC: known FP32 results for the directed vectors, integer a*b+c otherwise.
  function automatic logic [39:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    logic [31:0] z;
    logic [7:0]  s;
    case ({a, b, c})
      {32'h40000000, 32'h40400000, 32'h3F800000}: begin z = 32'h40E00000; s = 8'h00; end
      {32'h40800000, 32'h40000000, 32'h40E00000}: begin z = 32'h41700000; s = 8'h00; end
      {32'h7F7FFFFF, 32'h40000000, 32'h00000000}: begin z = 32'h7F800000; s = 8'h32; end
      {32'h3F800000, 32'h3F800000, 32'h7F800000}: begin z = 32'h7F800000; s = 8'h02; end
      default: begin z = a * b + c; s = z[7:0] & b[15:8]; end
    endcase
    return {s, z};
  endfunction

  assign {mac_status, mac_z} = mac_fn(mac_a, mac_b, mac_c);

  // Job-level reference: fold the MAC over the pairs, OR the flags, keep the final zero/inf.
  function automatic logic [39:0] ref_job(input int n, input logic [31:0] ci);
    logic [31:0] acc;
    logic [5:0]  sticky;
    logic [1:0]  lst;
    logic [39:0] r;
    acc = ci; sticky = 6'd0; lst = 2'd0;
    for (int i = 0; i < n; i++) begin
      r = mac_fn(pa[i], pb[i], acc);
      acc = r[31:0];
      sticky = sticky | r[39:34];
      lst = r[33:32];
    end
    return {sticky, lst, acc};
  endfunction

  task automatic run_job(input int n, input logic [31:0] ci, input logic [2:0] r,
                         input int bmode, input int hold, input bit glitch, input bit hs_start);
    int idx, cyc, bub;
    bit xfer, glitched;
    idx = 0; cyc = 0; bub = 0; glitched = 0;
    obs_stable = 1; obs_rnd_ok = 1; obs_ready_seen = 0; obs_timeout = 0;
    start = 1'b1; len = LW'(n); c_init = ci; rnd = r; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; rnd = ~r; len = LW'($urandom); c_init = $urandom; cyc = 1;
    while (!out_valid && cyc < 2000) begin
      start = 1'b0;
      if (glitch && !glitched && idx == 1) begin
        start = 1'b1; len = LW'(n + 3); c_init = $urandom; glitched = 1;
      end
      if (in_ready) begin
        obs_ready_seen = 1;
        if (mac_rnd !== r) obs_rnd_ok = 0;
      end
      if (idx < n) begin
        in_a = pa[idx]; in_b = pb[idx];
        if ((bmode == 1 && $urandom_range(0, 3) == 0) || (bmode == 2 && idx == 1 && bub < 2)) begin
          in_valid = 1'b0; bub++;
        end else begin
          in_valid = 1'b1;
        end
      end else begin
        in_valid = 1'b0;
      end
      xfer = in_valid && in_ready;
      @(posedge clk); #1; cyc++;
      if (xfer) idx++;
    end
    start = 1'b0; in_valid = 1'b0;
    obs_timeout = !out_valid; obs_lat = cyc; obs_bub = bub; obs_z = out_z; obs_st = out_status;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (out_z !== obs_z || out_status !== obs_st || out_valid !== 1'b1) obs_stable = 0;
    end
    out_ready = 1'b1;
    if (hs_start) begin start = 1'b1; len = LW'(0); c_init = $urandom; end
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    obs_idle_after = (busy === 1'b0 && out_valid === 1'b0 && in_ready === 1'b0);
    if (hs_start) begin
      @(posedge clk); #1;
      obs_idle_after = obs_idle_after && (busy === 1'b0 && out_valid === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_status, mac_rnd} !== 14'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {in_ready, out_valid, busy, out_status, mac_rnd});
    end
    checks++;
    if (out_z !== 32'd0 || mac_c !== 32'd0) begin
      errors++; $display("FAIL reset_data got out_z=%h mac_c=%h exp 0", out_z, mac_c);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic set_basic_pairs();
    pa[0] = 32'h40000000; pb[0] = 32'h40400000;
    pa[1] = 32'h40800000; pb[1] = 32'h40000000;
  endtask

  task automatic test_basic();
    set_basic_pairs();
    run_job(2, 32'h3F800000, 3'd0, 0, 0, 0, 0);
    checks++;
    if (obs_z !== 32'h41700000) begin errors++; $display("FAIL basic_z got %h exp 41700000", obs_z); end
    checks++;
    if (obs_st !== 8'h00) begin errors++; $display("FAIL basic_status got %h exp 00", obs_st); end
    checks++;
    if (obs_lat !== 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", obs_lat); end
    checks++;
    if (obs_idle_after !== 1'b1) begin errors++; $display("FAIL basic_idle got %b exp 1", obs_idle_after); end
  endtask

  task automatic test_len_zero();
    run_job(0, 32'h40400000, 3'd2, 0, 1, 0, 0);
    checks++;
    if (obs_z !== 32'h40400000) begin errors++; $display("FAIL len0_z got %h exp 40400000", obs_z); end
    checks++;
    if (obs_st !== 8'h00) begin errors++; $display("FAIL len0_status got %h exp 00", obs_st); end
    checks++;
    if (obs_lat !== 1) begin errors++; $display("FAIL len0_latency got %0d exp 1", obs_lat); end
    checks++;
    if (obs_ready_seen !== 1'b0) begin errors++; $display("FAIL len0_in_ready got %b exp 0", obs_ready_seen); end
  endtask

  task automatic test_bubbles_hold();
    set_basic_pairs();
    run_job(2, 32'h3F800000, 3'd0, 2, 3, 0, 0);
    checks++;
    if (obs_z !== 32'h41700000) begin errors++; $display("FAIL bubble_z got %h exp 41700000", obs_z); end
    checks++;
    if (obs_lat !== 5) begin errors++; $display("FAIL bubble_latency got %0d exp 5", obs_lat); end
    checks++;
    if (obs_stable !== 1'b1) begin errors++; $display("FAIL hold_stable got %b exp 1", obs_stable); end
    checks++;
    if (obs_idle_after !== 1'b1) begin errors++; $display("FAIL hold_idle got %b exp 1", obs_idle_after); end
  endtask

  task automatic test_overflow();
    pa[0] = 32'h7F7FFFFF; pb[0] = 32'h40000000;
    run_job(1, 32'h00000000, 3'd0, 0, 0, 0, 0);
    checks++;
    if (obs_z !== 32'h7F800000) begin errors++; $display("FAIL ovf_z got %h exp 7f800000", obs_z); end
    checks++;
    if (obs_st !== 8'h32) begin errors++; $display("FAIL ovf_status got %h exp 32", obs_st); end
    checks++;
    if (obs_lat !== 2) begin errors++; $display("FAIL ovf_latency got %0d exp 2", obs_lat); end
  endtask

  task automatic test_sticky();
    pa[0] = 32'h7F7FFFFF; pb[0] = 32'h40000000;
    pa[1] = 32'h3F800000; pb[1] = 32'h3F800000;
    run_job(2, 32'h00000000, 3'd0, 0, 0, 0, 0);
    checks++;
    if (obs_z !== 32'h7F800000) begin errors++; $display("FAIL sticky_z got %h exp 7f800000", obs_z); end
    checks++;
    if (obs_st !== 8'h32) begin errors++; $display("FAIL sticky_status got %h exp 32", obs_st); end
  endtask

  task automatic test_start_ignored();
    set_basic_pairs();
    run_job(2, 32'h3F800000, 3'd4, 0, 0, 1, 0);
    checks++;
    if (obs_z !== 32'h41700000) begin errors++; $display("FAIL ign_start_z got %h exp 41700000", obs_z); end
    checks++;
    if (obs_lat !== 3) begin errors++; $display("FAIL ign_start_latency got %0d exp 3", obs_lat); end
    checks++;
    if (obs_rnd_ok !== 1'b1) begin errors++; $display("FAIL ign_start_rnd got %b exp 1", obs_rnd_ok); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp;
    set_basic_pairs();
    run_job(2, 32'h3F800000, 3'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
    exp = ref_job(3, 32'h12345678);
    run_job(3, 32'h12345678, 3'd3, 0, 0, 0, 1);
    checks++;
    if ({obs_st, obs_z} !== exp) begin errors++; $display("FAIL b2b_result got %h exp %h", {obs_st, obs_z}, exp); end
    checks++;
    if (obs_lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", obs_lat); end
    checks++;
    if (obs_idle_after !== 1'b1) begin errors++; $display("FAIL hs_start_ignored got %b exp 1", obs_idle_after); end
  endtask

  task automatic test_reset_mid_job();
    bit bad;
    logic [39:0] exp;
    for (int i = 0; i < 4; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
    start = 1'b1; len = LW'(4); c_init = $urandom; rnd = 3'd1;
    in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; in_a = pa[1]; in_b = pb[1];
    @(posedge clk); #1; in_a = pa[2]; in_b = pb[2];
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got in_ready=%b busy=%b exp 0 0", in_ready, busy);
    end
    checks++;
    if (out_z !== 32'd0) begin errors++; $display("FAIL rst_mid_acc got %h exp 0", out_z); end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL rst_mid_no_output got %b exp 0", bad); end
    exp = ref_job(4, 32'h0BADF00D);
    run_job(4, 32'h0BADF00D, 3'd6, 0, 0, 0, 0);
    checks++;
    if ({obs_st, obs_z} !== exp) begin errors++; $display("FAIL rst_recover got %h exp %h", {obs_st, obs_z}, exp); end
  endtask

  task automatic test_random();
    logic [39:0] exp;
    logic [31:0] ci;
    logic [2:0]  r;
    int n, hold, exp_lat;
    for (int j = 0; j < 24; j++) begin
      if (j == 0) n = 255;
      else if (j == 1) n = 1;
      else n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin pa[i] = $urandom; pb[i] = $urandom; end
      ci = $urandom; r = 3'($urandom_range(0, 7)); hold = $urandom_range(0, 2);
      exp = ref_job(n, ci);
      run_job(n, ci, r, 1, hold, 0, 0);
      exp_lat = (n == 0) ? 1 : n + 1 + obs_bub;
      checks++;
      if ({obs_st, obs_z} !== exp) begin
        errors++; $display("FAIL rand_result job %0d len %0d got %h exp %h", j, n, {obs_st, obs_z}, exp);
      end
      checks++;
      if (obs_lat !== exp_lat || obs_timeout) begin
        errors++; $display("FAIL rand_latency job %0d got %0d exp %0d", j, obs_lat, exp_lat);
      end
      checks++;
      if (obs_rnd_ok !== 1'b1 || obs_stable !== 1'b1 || obs_idle_after !== 1'b1) begin
        errors++; $display("FAIL rand_ctrl job %0d got rnd_ok=%b stable=%b idle=%b exp 1 1 1",
                           j, obs_rnd_ok, obs_stable, obs_idle_after);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_bubbles_hold();
    test_overflow();
    test_sticky();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_job();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mac_accum_seq.md
# fp_mac_accum_seq

Sequential dot-product controller wrapped around a combinational floating-point multiply-add unit (z = a*b + c, 8-bit status). It accepts a stream of operand pairs over a valid/ready handshake and drives the MAC's a/b/c/rnd inputs, with c taken from its own accumulator register. It registers the MAC's z and status back into that accumulator and emits one rounded sum-of-products per job on an output handshake. The MAC sits outside this block, connected through the mac_* ports, so the same controller serves any MAC instance parameterisation.

## Interface
- SIG_WIDTH, 23, significand width; must match the attached MAC
- EXP_WIDTH, 8, exponent width; must match the attached MAC
- LEN_WIDTH, 8, width of the job length field
- W denotes SIG_WIDTH+EXP_WIDTH+1 below.

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job start pulse; sampled only in IDLE
- len  in  LEN_WIDTH  number of products in the job; sampled with start
- c_init  in  W  initial accumulator value; sampled with start
- rnd  in  3  rounding mode; sampled with start and held for the whole job
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts an operand pair
- in_a, in_b  in  W  operand pair
- mac_a, mac_b, mac_c  out  W  MAC operand inputs
- mac_rnd  out  3  MAC rounding mode
- mac_z  in  W  MAC result
- mac_status  in  8  MAC status
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_z  out  W  final accumulated value
- out_status  out  8  job status
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states are IDLE, ACC and DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: acc<=c_init, cnt<=len, rnd_r<=rnd, sticky<=0, last<=0.
  - Next state is DONE if len==0, otherwise ACC.
- ACC:
  - in_ready=1.
  - On a transfer (in_valid&&in_ready):
    - acc<=mac_z
    - sticky<=sticky|mac_status[7:2]
    - last<=mac_status[1:0]
    - cnt<=cnt-1
  - If cnt==1 at the transfer, next state is DONE.
  - With no transfer, all state holds.
- DONE:
  - out_valid=1, out_z=acc, out_status={sticky,last}.
  - On out_ready, go to IDLE.
  - out_z and out_status are stable while out_valid=1 and out_ready=0.
- MAC drive is combinational and present in every state: mac_a=in_a, mac_b=in_b, mac_c=acc, mac_rnd=rnd_r. The path in_a/in_b→MAC→acc completes in one cycle.
- start is ignored outside IDLE. len and c_init are don't-care when start=0.
- out_status bit semantics:
  - bits [7:2] are the OR of all MAC statuses in the job (invalid, tiny, huge, inexact, ...).
  - bits [1:0] are the zero/inf flags of the final MAC operation.
  - For len==0, out_status=0.
- No arithmetic is performed in this block. FP semantics, NaN and denormal handling are those of the attached MAC.

## Timing
- Reset (async assert, sync release): state=IDLE, acc=0, cnt=0, rnd_r=0, sticky=0, last=0. Outputs reset to in_ready=0, out_valid=0, busy=0, out_z=0, out_status=0, mac_c=0, mac_rnd=0.
- Reset mid-job aborts the job immediately with no output.
- Throughput is one operand pair per cycle while in ACC.
- Latency: if start is at cycle 0 with in_valid held high, the pairs transfer in cycles 1..len and out_valid rises in cycle len+1.
- For len==0, out_valid rises in cycle 1 with out_z=c_init.
- in_valid bubbles stretch the job by one cycle per bubble. The count is unaffected.
- The earliest next start is the cycle after the out_valid&&out_ready handshake. A start asserted in that same handshake cycle is ignored.
- busy goes high the cycle after start and low the cycle after the output handshake.

## Test plan
- FP32, c_init=0x3F800000 (1.0), len=2, rnd=0, pairs (0x40000000,0x40400000) then (0x40800000,0x40000000) back-to-back -> out_z=0x41700000 (15.0), out_status=0x00, out_valid in cycle 3.
- len=0, c_init=0x40400000 -> out_valid in cycle 1, out_z=0x40400000, out_status=0x00, in_ready never high.
- Same job as the first scenario with in_valid low for 2 cycles between the pairs, and out_ready held low 3 cycles in DONE -> out_z=0x41700000 held stable, out_valid in cycle 5, IDLE one cycle after out_ready rises.
- Overflow: c_init=0, len=1, pair (0x7F7FFFFF,0x40000000), rnd=0 -> out_z=0x7F800000, out_status=0x32 (inf, huge, inexact).
- Sticky status: len=2, first pair overflows to inf, second pair (0x3F800000,0x3F800000) -> out_status[4]=1, out_status[1]=1, out_z=0x7F800000.
- Reset and start interaction:
  - rst_n low in the middle of a 4-element ACC -> in_ready=0 and busy=0 immediately; no out_valid afterwards.
  - A start pulse during ACC is ignored: len is not re-sampled and the result is unchanged.
